// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types, default widths and helpers for the multi-port register file.
//   rf_state_t     : init-sequencer state (sweep in progress / normal operation)
//   RF_* params    : default widths and port counts used by regfile_mp
//   rf_match_t     : result of a priority search over write-port matches
//   rf_prio_match  : returns the highest-index set bit of a match mask
// -----------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_t;

   localparam int RF_DATA_W    = 32;
   localparam int RF_ADDR_W    = 5;
   localparam int RF_NRD       = 2;
   localparam int RF_NWR       = 2;

   // Upper bound on write ports the priority helper can search.
   localparam int RF_MAX_PORTS = 16;
   localparam int RF_IDX_W     = 4;

   typedef struct packed {
      logic                hit;
      logic [RF_IDX_W-1:0] idx;
   } rf_match_t;

   // Highest-index matching write port; ascending scan so the last hit wins,
   // which is the same priority the array write uses.
   function automatic rf_match_t rf_prio_match(input logic [RF_MAX_PORTS-1:0] mask);
      rf_match_t m;
      m.hit = 1'b0;
      m.idx = '0;
      for (int j = 0; j < RF_MAX_PORTS; j++) begin
         if (mask[j]) begin
            m.hit = 1'b1;
            m.idx = RF_IDX_W'(j);
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// -----------------------------------------------------------------------------
// regfile_init_seq
// Init sequencer: after reset, or on CLEAR while running, sweeps every entry
// of the array with zero (one entry per cycle) before normal operation.
// Ports:
//   CLK       in   clock
//   RESET_N   in   asynchronous active-low reset (restarts the sweep)
//   CLEAR     in   restart the sweep; ignored while a sweep is in progress
//   BUSY      out  1 while the sweep runs
//   INIT_WE   out  array write strobe for the sweep
//   INIT_ADDR out  entry being zeroed this cycle
// -----------------------------------------------------------------------------
module regfile_init_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              CLEAR,
   output logic              BUSY,
   output logic              INIT_WE,
   output logic [ADDR_W-1:0] INIT_ADDR
);

   rf_state_t         r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_busy;

   // Sweep FSM: counter walks 0..DEPTH-1 in INIT, then hands over to RUN.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= RF_INIT;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            RF_INIT: begin
               if (r_cnt == {ADDR_W{1'b1}}) begin
                  r_state <= RF_RUN;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt   <= r_cnt + ADDR_W'(1);
               end
            end
            RF_RUN: begin
               if (CLEAR) begin
                  r_state <= RF_INIT;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= RF_RUN;
               end
            end
            default: begin
               r_state <= RF_INIT;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   assign BUSY      = r_busy;
   assign INIT_WE   = r_busy;
   assign INIT_ADDR = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port register file: NRD registered read ports with write-first bypass,
// NWR write ports (highest port wins on address conflict), optional hardwired
// zero entry, and a hardware zeroing sweep after reset or CLEAR.
// Ports:
//   CLK      in   clock
//   RESET_N  in   asynchronous active-low reset
//   CLEAR    in   restart the zeroing sweep (ignored while BUSY)
//   BUSY     out  1 while the zeroing sweep runs
//   RD_ADDR  in   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   R_DATA   out  read data (1-cycle latency), port i at [i*DATA_W +: DATA_W]
//   WE       in   write enables, bit j = port j
//   WR_ADDR  in   write addresses, port j at [j*ADDR_W +: ADDR_W]
//   W_DATA   in   write data, port j at [j*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NRD      = RF_NRD,
   parameter int NWR      = RF_NWR,
   parameter int ZERO_REG = 1
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  CLEAR,
   output logic                  BUSY,
   input  logic [NRD*ADDR_W-1:0] RD_ADDR,
   output logic [NRD*DATA_W-1:0] R_DATA,
   input  logic [NWR-1:0]        WE,
   input  logic [NWR*ADDR_W-1:0] WR_ADDR,
   input  logic [NWR*DATA_W-1:0] W_DATA
);

   localparam int DEPTH = 2**ADDR_W;

   // Array contents are deliberately not reset; the sweep zeroes them.
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_init_we;
   logic [ADDR_W-1:0] w_init_addr;
   logic [NWR-1:0]    w_we_run;
   logic [NWR-1:0]    w_we_mem;

   regfile_init_seq #(
      .ADDR_W    (ADDR_W)
   ) u_init_seq (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .CLEAR     (CLEAR),
      .BUSY      (BUSY),
      .INIT_WE   (w_init_we),
      .INIT_ADDR (w_init_addr)
   );

   // Write enables qualified by RUN; array enables additionally drop entry 0
   // when it is hardwired to zero.
   always_comb begin
      w_we_run = '0;
      w_we_mem = '0;
      for (int j = 0; j < NWR; j++) begin
         if (w_init_we) begin
            w_we_run[j] = 1'b0;
            w_we_mem[j] = 1'b0;
         end else if ((ZERO_REG != 0) && (WR_ADDR[j*ADDR_W +: ADDR_W] == '0)) begin
            w_we_run[j] = WE[j];
            w_we_mem[j] = 1'b0;
         end else begin
            w_we_run[j] = WE[j];
            w_we_mem[j] = WE[j];
         end
      end
   end

   // Array write: sweep has exclusive access in INIT; in RUN the ascending
   // loop makes the highest-numbered port win on a shared address.
   always_ff @(posedge CLK) begin
      if (w_init_we) begin
         r_mem[w_init_addr] <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (w_we_mem[j]) begin
               r_mem[WR_ADDR[j*ADDR_W +: ADDR_W]] <= W_DATA[j*DATA_W +: DATA_W];
            end
         end
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0]       w_ra;
      logic [RF_MAX_PORTS-1:0] w_hit_mask;
      rf_match_t               w_match;
      logic [DATA_W-1:0]       w_next;
      logic [DATA_W-1:0]       r_rdata;

      assign w_ra = RD_ADDR[i*ADDR_W +: ADDR_W];

      // Which write ports target this read address in the current cycle.
      always_comb begin
         w_hit_mask = '0;
         for (int j = 0; j < NWR; j++) begin
            if (w_we_run[j] && (WR_ADDR[j*ADDR_W +: ADDR_W] == w_ra)) begin
               w_hit_mask[j] = 1'b1;
            end else begin
               w_hit_mask[j] = 1'b0;
            end
         end
      end

      assign w_match = rf_prio_match(w_hit_mask);

      // Next read value: sweep forces 0, zero entry beats bypass, bypass beats array.
      always_comb begin
         if (w_init_we) begin
            w_next = '0;
         end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
            w_next = '0;
         end else if (w_match.hit) begin
            w_next = W_DATA[32'(w_match.idx)*DATA_W +: DATA_W];
         end else begin
            w_next = r_mem[w_ra];
         end
      end

      // Read-data register, one cycle after address capture.
      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N) begin
            r_rdata <= '0;
         end else begin
            r_rdata <= w_next;
         end
      end

      assign R_DATA[i*DATA_W +: DATA_W] = r_rdata;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Drives two register files in parallel (zero entry on / off) with directed
// vectors, hand-written sweep/CLEAR/reset sequences and random traffic, and
// compares against an array-based reference model.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear = 1'b0;
   logic [1:0]  we = 2'b00;
   logic [4:0]  wa [2];
   logic [31:0] wd [2];
   logic [4:0]  ra [2];

   logic [9:0]  rd_addr_bus;
   logic [9:0]  wr_addr_bus;
   logic [63:0] w_data_bus;
   logic [63:0] rdata_z;
   logic [63:0] rdata_n;
   logic        busy_z;
   logic        busy_n;

   assign rd_addr_bus = {ra[1], ra[0]};
   assign wr_addr_bus = {wa[1], wa[0]};
   assign w_data_bus  = {wd[1], wd[0]};

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .ZERO_REG(1)) u_dut (
      .CLK(clk), .RESET_N(rst_n), .CLEAR(clear), .BUSY(busy_z),
      .RD_ADDR(rd_addr_bus), .R_DATA(rdata_z),
      .WE(we), .WR_ADDR(wr_addr_bus), .W_DATA(w_data_bus)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .ZERO_REG(0)) u_dut_nz (
      .CLK(clk), .RESET_N(rst_n), .CLEAR(clear), .BUSY(busy_n),
      .RD_ADDR(rd_addr_bus), .R_DATA(rdata_n),
      .WE(we), .WR_ADDR(wr_addr_bus), .W_DATA(w_data_bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: [0] = zero-entry instance, [1] = plain instance.
   logic [31:0] m_mem [2][32];
   int          busy_left = 0;

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [4:0]  ra0, ra1;
      logic [31:0] ez0, ez1, en0, en1;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      we = 2'b00; clear = 1'b0;
      wa[0] = 5'd0; wa[1] = 5'd0; wd[0] = 32'h0; wd[1] = 32'h0;
      ra[0] = 5'd0; ra[1] = 5'd0;
   endtask

   // One clock with the current inputs; model predicts, DUTs are compared.
   task automatic step();
      logic [31:0] exp_rd [2][2];
      bit was_busy;
      was_busy = (busy_left > 0);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (was_busy) exp_rd[k][i] = 32'h0;
            else if (k == 0 && ra[i] == 5'd0) exp_rd[k][i] = 32'h0;
            else begin
               exp_rd[k][i] = m_mem[k][ra[i]];
               for (int j = 0; j < 2; j++)
                  if (we[j] && wa[j] == ra[i]) exp_rd[k][i] = wd[j];
            end
         end
      end
      if (was_busy) begin
         for (int k = 0; k < 2; k++) m_mem[k][32 - busy_left] = 32'h0;
         busy_left--;
      end else begin
         for (int k = 0; k < 2; k++)
            for (int j = 0; j < 2; j++)
               if (we[j] && !(k == 0 && wa[j] == 5'd0)) m_mem[k][wa[j]] = wd[j];
         if (clear) busy_left = 32;
      end
      @(posedge clk); #1;
      check("busy_z", 32'(busy_z), 32'(busy_left > 0));
      check("busy_n", 32'(busy_n), 32'(busy_left > 0));
      check($sformatf("rd_z0 a=%0d", ra[0]), rdata_z[31:0],  exp_rd[0][0]);
      check($sformatf("rd_z1 a=%0d", ra[1]), rdata_z[63:32], exp_rd[0][1]);
      check($sformatf("rd_n0 a=%0d", ra[0]), rdata_n[31:0],  exp_rd[1][0]);
      check($sformatf("rd_n1 a=%0d", ra[1]), rdata_n[63:32], exp_rd[1][1]);
   endtask

   // Assert reset, confirm the async reset values, release away from an edge.
   task automatic apply_reset(input int hold);
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy_z), 32'h1);
      check("rst_rdata_z", rdata_z[31:0] | rdata_z[63:32], 32'h0);
      check("rst_rdata_n", rdata_n[31:0] | rdata_n[63:32], 32'h0);
      busy_left = 32;
      repeat (hold) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Step until BUSY drops (bounded) and compare the number of cycles taken.
   task automatic count_busy(input string name, input int exp_cycles);
      int n;
      n = 0;
      while (busy_z === 1'b1 && n < 100) begin
         step();
         n++;
      end
      check(name, 32'(n), 32'(exp_cycles));
   endtask

   initial begin
      idle_inputs();
      #2;

      // Reset and initial sweep
      apply_reset(2);
      count_busy("reset_sweep_len", 32);
      for (int a = 0; a < 16; a++) begin
         ra[0] = 5'(a); ra[1] = 5'(a + 16);
         step();
         check($sformatf("sweep_zero a=%0d", a), rdata_n[31:0] | rdata_n[63:32], 32'h0);
      end

      // Directed vectors with independently written expectations
      vecs[0] = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0};
      vecs[1] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2] = '{2'b10, 5'd0, 5'd7, 32'h0,        32'h1234,     5'd5, 5'd7, 32'hDEADBEEF, 32'h1234,     32'hDEADBEEF, 32'h1234};
      vecs[3] = '{2'b11, 5'd9, 5'd9, 32'hA,        32'hB,        5'd9, 5'd7, 32'hB,        32'h1234,     32'hB,        32'h1234};
      vecs[4] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd9, 5'd9, 32'hB,        32'hB,        32'hB,        32'hB};
      vecs[5] = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[6] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd0, 5'd9, 32'h0,        32'hB,        32'hFFFFFFFF, 32'hB};
      vecs[7] = '{2'b11, 5'd3, 5'd0, 32'h55,       32'h12345678, 5'd3, 5'd0, 32'h55,       32'h0,        32'h55,       32'h12345678};
      vecs[8] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd3, 5'd0, 32'h55,       32'h0,        32'h55,       32'h12345678};
      vecs[9] = '{2'b11, 5'd0, 5'd0, 32'h1,        32'h2,        5'd0, 5'd0, 32'h0,        32'h0,        32'h2,        32'h2};
      for (int v = 0; v < 10; v++) begin
         we = vecs[v].we; wa[0] = vecs[v].wa0; wa[1] = vecs[v].wa1;
         wd[0] = vecs[v].wd0; wd[1] = vecs[v].wd1;
         ra[0] = vecs[v].ra0; ra[1] = vecs[v].ra1;
         step();
         check($sformatf("vec%0d z0", v), rdata_z[31:0],  vecs[v].ez0);
         check($sformatf("vec%0d z1", v), rdata_z[63:32], vecs[v].ez1);
         check($sformatf("vec%0d n0", v), rdata_n[31:0],  vecs[v].en0);
         check($sformatf("vec%0d n1", v), rdata_n[63:32], vecs[v].en1);
      end

      // CLEAR together with a write: write commits, then full sweep
      idle_inputs();
      we = 2'b01; wa[0] = 5'd12; wd[0] = 32'hCAFE; ra[0] = 5'd12; clear = 1'b1;
      step();
      check("clear_bypass", rdata_z[31:0], 32'hCAFE);
      idle_inputs();
      ra[0] = 5'd3; ra[1] = 5'd12;
      count_busy("clear_sweep_len", 32);
      step();
      check("clear_addr3", rdata_z[31:0], 32'h0);
      check("clear_addr12", rdata_n[63:32], 32'h0);

      // CLEAR while busy is ignored
      clear = 1'b1; step();
      clear = 1'b0; repeat (5) step();
      clear = 1'b1; step();
      clear = 1'b0;
      count_busy("clear_ignored_len", 26);

      // Reset at sweep cycle 10 restarts a full sweep
      clear = 1'b1; step();
      clear = 1'b0; repeat (10) step();
      apply_reset(2);
      count_busy("reset_mid_sweep_len", 32);

      // Random traffic with occasional CLEAR and forced address collisions
      for (int c = 0; c < 400; c++) begin
         we    = 2'($urandom);
         wa[0] = 5'($urandom_range(0, 31));
         wa[1] = ($urandom_range(0, 3) == 0) ? wa[0] : 5'($urandom_range(0, 31));
         wd[0] = $urandom; wd[1] = $urandom;
         ra[0] = ($urandom_range(0, 2) == 0) ? wa[0] : 5'($urandom_range(0, 31));
         ra[1] = ($urandom_range(0, 2) == 0) ? wa[1] : 5'($urandom_range(0, 31));
         clear = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
